// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared types and field layout for the PS/2 mouse receiver.
//   byte_state_t  : per-byte receive states (start/data/parity/stop)
//   pkt_state_t   : position within the 3-byte movement packet
//   mouse_word_t  : 25-bit packet word {toggle, Y, X, status}
// Optional feature macro: PS2_MOUSE_PARITY_CHECK_EN (odd parity enforced when defined).
package ps2_mouse_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} byte_state_t;
    typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 25;
    localparam int unsigned STAT_LSB = 0;
    localparam int unsigned X_LSB    = 8;
    localparam int unsigned Y_LSB    = 16;
    localparam int unsigned STB_BIT  = 24;
    localparam int unsigned SYNC_BIT = 3;

    typedef struct packed {
        logic              stb;
        logic [BYTE_W-1:0] y;
        logic [BYTE_W-1:0] x;
        logic [BYTE_W-1:0] stat;
    } mouse_word_t;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_ok(input logic [BYTE_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: PS/2 device->host byte receiver.
//   Synchronises and glitch-filters ps2_clk/ps2_dat, samples data on filtered
//   falling clock edges and frames start/8 data/parity/stop bits.
// Ports:
//   clk_i, reset_i       system clock, async active-high reset
//   ps2_clk_i, ps2_dat_i raw PS/2 lines (async, idle high)
//   byte_vld_o           one-clk pulse when a frame completes
//   byte_o, byte_err_o   received byte and its error flag (bad stop / bad parity)
//   resync_o             one-clk pulse when the bus has been idle for TIMEOUT clks
// Optional feature macro: PS2_MOUSE_PARITY_CHECK_EN.
module ps2_rx_byte
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ps2_clk_i,
    input  logic              ps2_dat_i,
    output logic              byte_vld_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_err_o,
    output logic              resync_o
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned BIT_W  = $clog2(BYTE_W);

    // Index 0 carries ps2_clk, index 1 carries ps2_dat.
    logic [1:0]             meta_q;
    logic [1:0]             sync_q;
    logic [1:0]             filt_q;
    logic [1:0][FCNT_W-1:0] fcnt_q;
    logic [1:0]             accept;

    logic                   clk_edge;
    logic                   clk_fall;
    logic                   dat_s;

    logic [TO_W-1:0]        to_cnt_q;
    logic                   to_hit;
    logic                   resync_q;

    byte_state_t            state_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [BYTE_W-1:0]      shift_q;
    logic                   byte_vld_q;
    logic [BYTE_W-1:0]      byte_q;
    logic                   byte_err_q;
`ifdef PS2_MOUSE_PARITY_CHECK_EN
    logic                   par_q;
`endif

    // A new level is accepted once it has differed from the filtered level for FILTER_LEN clks.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync_q[i] != filt_q[i]) && (fcnt_q[i] == FCNT_W'(FILTER_LEN - 1));
        end
    end

    assign clk_edge = accept[0];
    assign clk_fall = accept[0] & filt_q[0];
    assign dat_s    = filt_q[1];

    // Synchroniser and stability filter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= '1;
            sync_q <= '1;
            filt_q <= '1;
            fcnt_q <= '0;
        end else begin
            meta_q <= {ps2_dat_i, ps2_clk_i};
            sync_q <= meta_q;
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else if (sync_q[i] != filt_q[i]) begin
                    fcnt_q[i] <= fcnt_q[i] + FCNT_W'(1);
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    // Idle timeout reaches its limit this clk; a coincident clock edge takes priority.
    assign to_hit = !clk_edge && (to_cnt_q == TO_W'(TIMEOUT - 1));

    // Saturating idle counter, cleared by any filtered clock edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            to_cnt_q <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= to_hit;
            if (clk_edge) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
        end
    end

    // Byte framing FSM, advanced on filtered falling clock edges.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            byte_err_q <= 1'b0;
`ifdef PS2_MOUSE_PARITY_CHECK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            byte_vld_q <= 1'b0;
            if (clk_fall) begin
                case (state_q)
                    IDLE: begin
                        // A high sample here is not a start bit and is dropped.
                        if (!dat_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s, shift_q[BYTE_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_MOUSE_PARITY_CHECK_EN
                        par_q <= dat_s;
`endif
                        state_q <= STOP;
                    end
                    STOP: begin
                        byte_vld_q <= 1'b1;
                        byte_q     <= shift_q;
`ifdef PS2_MOUSE_PARITY_CHECK_EN
                        byte_err_q <= !dat_s || !odd_ok(shift_q, par_q);
`else
                        byte_err_q <= !dat_s;
`endif
                        state_q    <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (to_hit) begin
                state_q <= IDLE;
            end
        end
    end

    assign byte_vld_o = byte_vld_q;
    assign byte_o     = byte_q;
    assign byte_err_o = byte_err_q;
    assign resync_o   = resync_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: assembles 3-byte PS/2 mouse movement packets into the 25-bit
//   ps2_mouse word {toggle, Y[7:0], X[7:0], status[7:0]}.
// Ports:
//   clk, reset               system clock, async active-high reset
//   ps2_clk_in, ps2_dat_in   raw PS/2 lines from the mouse (idle high)
//   ps2_mouse                packet word; bit 24 toggles once per completed packet
//   frame_err                one-clk pulse on a discarded byte or packet
// Optional feature macro: PS2_MOUSE_PARITY_CHECK_EN (odd parity enforced when defined).
module ps2_mouse_rx
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ps2_clk_in,
    input  logic              ps2_dat_in,
    output logic [WORD_W-1:0] ps2_mouse,
    output logic              frame_err
);

    logic              byte_vld;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_err;
    logic              resync;

    pkt_state_t        pkt_q;
    logic [BYTE_W-1:0] stat_q;
    logic [BYTE_W-1:0] x_q;
    mouse_word_t       mouse_q;
    logic              frame_err_q;

    ps2_rx_byte #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx_byte (
        .clk_i      (clk),
        .reset_i    (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .byte_vld_o (byte_vld),
        .byte_o     (rx_byte),
        .byte_err_o (byte_err),
        .resync_o   (resync)
    );

    // Packet FSM: bytes go to shadow registers; the output word changes only on the third byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q       <= B0;
            stat_q      <= '0;
            x_q         <= '0;
            mouse_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (byte_vld) begin
                if (byte_err) begin
                    frame_err_q <= 1'b1;
                    pkt_q       <= B0;
                end else begin
                    case (pkt_q)
                        B0: begin
                            // Status bytes always have bit 3 set; anything else means we are out of sync.
                            if (rx_byte[SYNC_BIT]) begin
                                stat_q <= rx_byte;
                                pkt_q  <= B1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                        B1: begin
                            x_q   <= rx_byte;
                            pkt_q <= B2;
                        end
                        B2: begin
                            mouse_q <= '{stb: ~mouse_q.stb, y: rx_byte, x: x_q, stat: stat_q};
                            pkt_q   <= B0;
                        end
                        default: pkt_q <= B0;
                    endcase
                end
            end else if (resync) begin
                pkt_q <= B0;
            end
        end
    end

    assign ps2_mouse[STAT_LSB +: BYTE_W] = mouse_q.stat;
    assign ps2_mouse[X_LSB +: BYTE_W]    = mouse_q.x;
    assign ps2_mouse[Y_LSB +: BYTE_W]    = mouse_q.y;
    assign ps2_mouse[STB_BIT]            = mouse_q.stb;
    assign frame_err                     = frame_err_q;

endmodule
